cosine_cordic: RTL and testbench
================================

// Module: cosine_cordic
// PURPOSE
//   Pipelined CORDIC (rotation mode) that computes cos(theta).
//   Input theta is an IEEE-754 single-precision angle in radians, range [-1.0, +1.0].
//   Output is two's-complement fixed point Q2.30 (30 fractional bits; 1.0 = 0x40000000).
//   Accepts one sample per clock and sits as a math leaf in the datapath.
// PARAMETERS
//   ITERATIONS  16  Number of CORDIC micro-rotations, one pipeline stage each (range 8..30).
//   FRAC_BITS   30  Fractional bits of the internal and output fixed-point format (fixed at 30).
// PORTS
//   clk        in   1   Single clock; all state updates on the rising edge.
//   rst        in   1   Asynchronous, active-high reset.
//   in_valid   in   1   Qualifies theta on this cycle.
//   theta      in   32  IEEE-754 single-precision angle, radians.
//   out_valid  out  1   Qualifies result.
//   result     out  32  cos(theta), signed Q2.30.
// BEHAVIOUR
//   Reset: all stage valid bits, out_valid and result clear to 0 immediately.
//     Pipeline contents are discarded. Reset applied mid-stream drops every in-flight sample.
//   Throughput: 1 sample/cycle. No backpressure and no stall input.
//   Latency: out_valid/result appear exactly ITERATIONS+1 cycles after the in_valid edge.
//   Stage 0 (float->fixed, registered):
//     - cos is even, so use |theta|; the sign bit is ignored.
//     - exp==0 (zero or denormal), or exp < 127-30: z0 = 0.
//     - 97 <= exp <= 127: z0 = {1,mantissa} shifted to Q2.30, truncating.
//     - exp > 127 (|theta|>1, inf, NaN): z0 clamps to 1.0 (0x40000000).
//     - Initial x0 = K = 0x26DD3B6A (0.6072529350). y0 = 0.
//   Stage i (i = 0..ITERATIONS-1), d = (z >= 0) ? +1 : -1:
//     x' = x - d*(y>>>i)
//     y' = y + d*(x>>>i)
//     z' = z - d*atan(2^-i)
//   Arithmetic rules:
//     - Shifts are arithmetic (sign-preserving).
//     - All math is 32-bit two's complement; no overflow occurs for |theta| <= 1.
//   Output: result = x of the final stage. y and z are discarded.
//   Accuracy: |result - cos(theta)| <= 2^-14 (0x10000 LSB) for ITERATIONS = 16.
//   Samples with in_valid = 0 still propagate data but carry valid = 0.
//     Their result values are don't-care.
// STRUCTURE
//   Package cordic_pkg:
//     - Constant CORDIC_K = 32'h26DD3B6A.
//     - Function or array ATAN_TABLE[0..29] in Q2.30:
//       atan(2^0) = 0x3243F6A9, atan(2^-1) = 0x1DAC6705, atan(2^-2) = 0x0FADBAFD, ...
//     - Typedef for the {x, y, z, valid} stage record.
//   Sub-module: cordic_stage, parameterised by shift index I.
//     One registered micro-rotation with async reset.
//     The top level instantiates it ITERATIONS times via generate.
// TESTING
//   1. theta = 0x3F800000 (1.0) -> result ~0x2294501F (0.540302), after 17 cycles.
//   2. theta = 0xBF800000 (-1.0) -> same result as case 1 (cos is even).
//   3. theta = 0x00000000 and 0x30800000 (2^-30) -> result ~0x40000000 (1.0).
//   4. theta = 0x3F000000 (0.5) -> result ~0x382A4C28 (0.877583).
//   5. Back-to-back stream of cases 1..4 with in_valid high for 4 cycles
//      -> 4 consecutive out_valid cycles, results in order.
//      Then assert rst mid-stream -> out_valid drops at once and no stale outputs follow.
//   6. theta = 0x40000000 (2.0) and theta = NaN -> clamped, result ~0x2294501F.
//   All value checks use tolerance ±0x10000.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and the stage record type for the cosine CORDIC pipeline.
// Angles and coordinates are signed Q2.30.
package cordic_pkg;

    localparam logic [31:0] CORDIC_K = 32'h26DD3B6A;

    typedef struct packed {
        logic        valid;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } cordic_stage_t;

    // atan(2^-idx) in Q2.30, rounded to nearest; indices beyond 29 fall to zero.
    function automatic logic [31:0] atan_lut(input int idx);
        logic [31:0] v;
        case (idx)
            0:  v = 32'h3243F6A9;
            1:  v = 32'h1DAC6705;
            2:  v = 32'h0FADBAFD;
            3:  v = 32'h07F56EA7;
            4:  v = 32'h03FEAB77;
            5:  v = 32'h01FFD55C;
            6:  v = 32'h00FFFAAB;
            7:  v = 32'h007FFF55;
            8:  v = 32'h003FFFEB;
            9:  v = 32'h001FFFFD;
            10: v = 32'h00100000;
            11: v = 32'h00080000;
            12: v = 32'h00040000;
            13: v = 32'h00020000;
            14: v = 32'h00010000;
            15: v = 32'h00008000;
            16: v = 32'h00004000;
            17: v = 32'h00002000;
            18: v = 32'h00001000;
            19: v = 32'h00000800;
            20: v = 32'h00000400;
            21: v = 32'h00000200;
            22: v = 32'h00000100;
            23: v = 32'h00000080;
            24: v = 32'h00000040;
            25: v = 32'h00000020;
            26: v = 32'h00000010;
            27: v = 32'h00000008;
            28: v = 32'h00000004;
            29: v = 32'h00000002;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation (rotation mode) with shift index I.
// Drives z toward zero; x accumulates the cosine.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int I = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  cordic_stage_t i_stage,
    output cordic_stage_t o_stage
);

    localparam logic [31:0] ATAN_I = atan_lut(I);

    logic        w_d_pos;
    logic [31:0] w_x_sh;
    logic [31:0] w_y_sh;

    cordic_stage_t r_stage;

    assign w_d_pos = ~i_stage.z[31];
    assign w_x_sh  = $signed(i_stage.x) >>> I;
    assign w_y_sh  = $signed(i_stage.y) >>> I;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage.valid <= i_stage.valid;
            if (w_d_pos) begin
                r_stage.x <= i_stage.x - w_y_sh;
                r_stage.y <= i_stage.y + w_x_sh;
                r_stage.z <= i_stage.z - ATAN_I;
            end else begin
                r_stage.x <= i_stage.x + w_y_sh;
                r_stage.y <= i_stage.y - w_x_sh;
                r_stage.z <= i_stage.z + ATAN_I;
            end
        end
    end

    assign o_stage = r_stage;

endmodule

// File: rtl/cosine_cordic.sv
// Pipelined cos(theta): float angle -> Q2.30 in a registered front stage,
// then ITERATIONS registered micro-rotations. One sample per clock.
module cosine_cordic
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 16,
    parameter int FRAC_BITS  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] theta,
    output logic        out_valid,
    output logic [31:0] result
);

    localparam logic [31:0] ONE_Q   = 32'(1) << FRAC_BITS;
    localparam logic [7:0]  EXP_MIN = 8'(127 - FRAC_BITS);

    logic [7:0]  w_exp;
    logic [31:0] w_mant_q;
    logic [31:0] w_z0;
    logic        w_unused_sign;
    logic [63:0] w_unused_yz;

    cordic_stage_t r_stage0;
    cordic_stage_t w_pipe [0:ITERATIONS];

    // cos is even, so the sign bit plays no part in the angle.
    assign w_unused_sign = theta[31];
    assign w_exp         = theta[30:23];
    assign w_mant_q      = {8'b0, 1'b1, theta[22:0]} << (FRAC_BITS - 23);

    always_comb begin
        w_z0 = '0;
        if (w_exp > 8'd127) begin
            w_z0 = ONE_Q;
        end else if (w_exp >= EXP_MIN) begin
            w_z0 = w_mant_q >> (8'd127 - w_exp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage0 <= '0;
        end else begin
            r_stage0.valid <= in_valid;
            r_stage0.x     <= CORDIC_K;
            r_stage0.y     <= '0;
            r_stage0.z     <= w_z0;
        end
    end

    assign w_pipe[0] = r_stage0;

    for (genvar gi = 0; gi < ITERATIONS; gi++) begin : g_stage
        cordic_stage #(
            .I(gi)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_stage(w_pipe[gi]),
            .o_stage(w_pipe[gi+1])
        );
    end

    assign out_valid   = w_pipe[ITERATIONS].valid;
    assign result      = w_pipe[ITERATIONS].x;
    assign w_unused_yz = {w_pipe[ITERATIONS].y, w_pipe[ITERATIONS].z};

endmodule

// File: tb/tb_cosine_cordic.sv
// Bench for cosine_cordic: driver pushes expected cosines into a queue,
// a negedge monitor pops and compares value (within tolerance) and arrival cycle.
module tb_cosine_cordic;

    localparam int          ITER = 16;
    localparam int          LAT  = ITER + 1;
    localparam int          TOL  = 32'h10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] theta;
    logic        out_valid;
    logic [31:0] result;

    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];

    cosine_cordic #(
        .ITERATIONS(ITER),
        .FRAC_BITS (30)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .theta    (theta),
        .out_valid(out_valid),
        .result   (result)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Decode the float as a real angle, clamp |theta| > 1 / inf / NaN to 1.0,
    // and return round(cos(angle) * 2^30).
    function automatic logic [31:0] ref_cos(input logic [31:0] t);
        int  e;
        real a;
        e = int'(t[30:23]);
        if (e == 0) begin
            a = 0.0;
        end else if (e == 255) begin
            a = 1.0;
        end else begin
            a = (1.0 + real'(t[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
            if (a > 1.0) a = 1.0;
        end
        return 32'($rtoi($cos(a) * 1073741824.0 + 0.5));
    endfunction

    function automatic logic [31:0] rand_theta();
        int          kind;
        logic        s;
        logic [7:0]  e;
        logic [31:0] m;
        kind = $urandom_range(0, 9);
        s    = 1'($urandom_range(0, 1));
        m    = $urandom();
        case (kind)
            0:       e = 8'($urandom_range(0, 96));
            1:       e = 8'($urandom_range(128, 255));
            2:       return {s, 8'd127, 23'd0};
            default: e = 8'($urandom_range(97, 126));
        endcase
        return {s, e, m[22:0]};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic ok, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic v, input logic [31:0] t, input logic [31:0] e);
        @(negedge clk);
        in_valid = v;
        theta    = t;
        if (v) begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc + LAT);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, $urandom(), 32'h0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        int          c;
        int          d;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1'b0, result, 32'h0);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                d = $signed(result) - $signed(e);
                if (d < 0) d = -d;
                check("cos_value", d <= TOL, result, e);
                check("latency", cyc == c, 32'(cyc), 32'(c));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] t;
        rst      = 1'b1;
        in_valid = 1'b0;
        theta    = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid == 1'b0, {31'b0, out_valid}, 32'h0);
        check("reset_result", result == 32'h0, result, 32'h0);
        rst = 1'b0;
        idle(2);

        // Directed cases, the first four back-to-back.
        send(1'b1, 32'h3F800000, 32'h2294501F);
        send(1'b1, 32'hBF800000, 32'h2294501F);
        send(1'b1, 32'h00000000, 32'h40000000);
        send(1'b1, 32'h3F000000, 32'h382A4C28);
        send(1'b1, 32'h30800000, 32'h40000000);
        idle(3);
        send(1'b1, 32'h40000000, 32'h2294501F);
        send(1'b1, 32'h7FC00000, 32'h2294501F);
        send(1'b1, 32'hFF800000, 32'h2294501F);
        idle(LAT + 4);

        // Randomized stream with gaps.
        for (int i = 0; i < 300; i++) begin
            t = rand_theta();
            if ($urandom_range(0, 3) != 0) send(1'b1, t, ref_cos(t));
            else                           send(1'b0, t, 32'h0);
        end
        idle(LAT + 4);

        // Mid-stream reset: outputs must be flowing, then vanish at once.
        for (int i = 0; i < LAT + 3; i++) begin
            t = rand_theta();
            send(1'b1, t, ref_cos(t));
        end
        #1;
        check("stream_flowing", out_valid == 1'b1, {31'b0, out_valid}, 32'h1);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midreset_out_valid", out_valid == 1'b0, {31'b0, out_valid}, 32'h0);
        check("midreset_result", result == 32'h0, result, 32'h0);
        exp_q.delete();
        cyc_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(LAT + 10);

        // Pipeline works again after reset.
        send(1'b1, 32'h3F000000, 32'h382A4C28);
        send(1'b1, 32'hBF800000, 32'h2294501F);
        idle(LAT + 4);

        check("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
